// File: rtl/bcd_display_mux.sv
// Four-digit multiplexed common-anode seven-segment driver: snapshots BCD digits
// on LOAD, scans them with a guard interval, blanks leading zeros, flags bad BCD.
module bcd_display_mux #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 4,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       LOAD,
    input  logic [3:0] BCD_0,
    input  logic [3:0] BCD_1,
    input  logic [3:0] BCD_2,
    input  logic [3:0] BCD_3,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic       ERR
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GUARD = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam logic [CW-1:0] CNT_GUARD_END = CW'(GUARD - 1);
    localparam logic [CW-1:0] CNT_LAST      = CW'(REFRESH_DIV - 1);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            err_q, err_d;
    logic [3:0]      blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        dig_d = dig_q;
        if (LOAD) begin
            dig_d = {BCD_3, BCD_2, BCD_1, BCD_0};
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!EN) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                ST_GUARD: begin
                    if (cnt_q == CNT_GUARD_END) begin
                        state_d = ST_DRIVE;
                    end
                    cnt_d = cnt_q + 1'b1;
                end
                ST_DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_GUARD;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        // Outputs are built from next-state values so a capture shows on SEG one cycle later.
        blank[3] = BLANK_LZ && (dig_d[3] == 4'd0);
        blank[2] = blank[3] && (dig_d[2] == 4'd0);
        blank[1] = blank[2] && (dig_d[1] == 4'd0);
        blank[0] = 1'b0;

        an_d  = '1;
        seg_d = '1;
        if (state_d == ST_DRIVE) begin
            an_d[idx_d] = 1'b0;
            seg_d       = blank[idx_d] ? 7'h7F : decode(dig_d[idx_d]);
        end

        err_d = (dig_q[0] > 4'd9) | (dig_q[1] > 4'd9) | (dig_q[2] > 4'd9) | (dig_q[3] > 4'd9);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            dig_q   <= '0;
            seg_q   <= '1;
            an_q    <= '1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            err_q   <= err_d;
        end
    end

    assign SEG = seg_q;
    assign AN  = an_q;
    assign ERR = err_q;

endmodule
